hdmi_i2c_init_seq: RTL

//  Sequencer that configures the HDMI transmitter over the shared i2c_master after power-up/hot-plug.

---
 rtl/hdmi_i2c_init_seq.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/hdmi_i2c_init_seq.sv
// Power-up / hot-plug configuration sequencer for the HDMI transmitter.
// Walks a {subaddr,data} table, issuing one i2c write per entry with ack check, retry and timeout.
module hdmi_i2c_init_seq #(
    parameter int         CLK_HZ    = 24_000_000,
    parameter logic [6:0] DEV_ADDR  = 7'h39,
    parameter int         TBL_AW    = 5,
    parameter int         PWR_DLY   = 240_000,
    parameter int         TIMEOUT   = 48_000,
    parameter int         RETRY_MAX = 3,
    parameter int         RETRY_GAP = 2_400
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              start,
    input  logic              hdmi_int,
    output logic [TBL_AW-1:0] tbl_addr,
    input  logic [15:0]       tbl_data,
    output logic              i2c_start,
    output logic              i2c_read,
    output logic [6:0]        i2c_addr,
    output logic [7:0]        i2c_subaddr,
    output logic [7:0]        i2c_dout,
    input  logic              i2c_end,
    input  logic              i2c_ack,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int CNT_MAX = (PWR_DLY > TIMEOUT)
                           ? ((PWR_DLY > RETRY_GAP) ? PWR_DLY : RETRY_GAP)
                           : ((TIMEOUT > RETRY_GAP) ? TIMEOUT : RETRY_GAP);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int RTY_W   = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;

    localparam logic [CNT_W-1:0]  PWR_LAST = CNT_W'(PWR_DLY - 1);
    localparam logic [CNT_W-1:0]  TO_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  GAP_LAST = CNT_W'(RETRY_GAP - 1);
    localparam logic [RTY_W-1:0]  RTY_LIM  = RTY_W'(RETRY_MAX);
    localparam logic [TBL_AW-1:0] IDX_LAST = '1;
    localparam logic [15:0]       END_MARK = 16'hFFFF;

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] WAIT_PWR = 3'd1;
    localparam logic [2:0] FETCH    = 3'd2;
    localparam logic [2:0] ISSUE    = 3'd3;
    localparam logic [2:0] WAIT_END = 3'd4;
    localparam logic [2:0] GAP      = 3'd5;
    localparam logic [2:0] DONE     = 3'd6;
    localparam logic [2:0] FAIL     = 3'd7;

    generate
        if (CLK_HZ <= 0 || TBL_AW < 1 || PWR_DLY < 1 || TIMEOUT < 1 || RETRY_GAP < 1 || RETRY_MAX < 0)
        begin : g_bad_param
            $error("hdmi_i2c_init_seq: invalid parameter set");
        end
    endgenerate

    logic [2:0]        state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [TBL_AW-1:0] idx, idx_nxt;
    logic [RTY_W-1:0]  retry, retry_nxt;
    logic              pending, pending_nxt;
    logic              fetch_ph, fetch_ph_nxt;
    logic [7:0]        sub_nxt, dout_nxt;
    logic [2:0]        int_sync;
    logic              int_fall, trig, run_active;

    // HDMI_INT idles high; the synchroniser resets high so reset release never looks like an edge.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            int_sync <= 3'b111;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            int_sync <= {int_sync[1:0], hdmi_int};
        end
    end

    assign int_fall   = int_sync[2] & ~int_sync[1];
    assign trig       = start | int_fall;
    assign run_active = !(state inside {IDLE, DONE, FAIL});

    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
        state_nxt    = state;
        cnt_nxt      = cnt;
        idx_nxt      = idx;
        retry_nxt    = retry;
        pending_nxt  = pending | (trig & run_active);
        fetch_ph_nxt = 1'b0;
        sub_nxt      = i2c_subaddr;
        dout_nxt     = i2c_dout;

        case (state)
            IDLE, DONE, FAIL: begin
                if (trig) begin
                    state_nxt = WAIT_PWR;
                    cnt_nxt   = '0;
                    retry_nxt = '0;
                end
            end
            WAIT_PWR: begin
                if (cnt == PWR_LAST) begin
                    state_nxt = FETCH;
                    cnt_nxt   = '0;
                    idx_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            FETCH: begin
                // First cycle presents the address; table data is valid on the second.
                if (!fetch_ph) begin
                    fetch_ph_nxt = 1'b1;
                end else if (tbl_data == END_MARK) begin
                    state_nxt = DONE;
                end else begin
                    sub_nxt   = tbl_data[15:8];
                    dout_nxt  = tbl_data[7:0];
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                cnt_nxt   = '0;
                state_nxt = WAIT_END;
            end
            WAIT_END: begin
                // i2c_end takes priority over a timeout expiring in the same cycle.
                if (i2c_end && i2c_ack) begin
                    retry_nxt = '0;
                    if (idx == IDX_LAST) begin
                        state_nxt = DONE;
                    end else begin
                        idx_nxt   = idx + 1'b1;
                        state_nxt = FETCH;
                    end
                end else if (i2c_end || cnt == TO_LAST) begin
                    cnt_nxt = '0;
                    if (retry < RTY_LIM) begin
                        retry_nxt = retry + 1'b1;
                        state_nxt = GAP;
                    end else begin
                        state_nxt = FAIL;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            GAP: begin
                if (cnt == GAP_LAST) begin
                    state_nxt = ISSUE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // A trigger seen during the run supersedes its result: restart without flagging done/error.
        if (run_active && (state_nxt == DONE || state_nxt == FAIL) && (pending || trig)) begin
            state_nxt   = WAIT_PWR;
            cnt_nxt     = '0;
            retry_nxt   = '0;
            pending_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state       <= WAIT_PWR;
            cnt         <= '0;
            idx         <= '0;
            retry       <= '0;
            pending     <= 1'b0;
            fetch_ph    <= 1'b0;
            i2c_subaddr <= 8'h00;
            i2c_dout    <= 8'h00;
            i2c_start   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            idx         <= idx_nxt;
            retry       <= retry_nxt;
            pending     <= pending_nxt;
            fetch_ph    <= fetch_ph_nxt;
            i2c_subaddr <= sub_nxt;
            i2c_dout    <= dout_nxt;
            i2c_start   <= (state_nxt == ISSUE);
            busy        <= !(state_nxt inside {IDLE, DONE, FAIL});
            done        <= (state_nxt == DONE);
            error       <= (state_nxt == FAIL);
        end
    end

    assign tbl_addr = idx;
    assign i2c_read = 1'b0;
    assign i2c_addr = DEV_ADDR;

endmodule
